// File: rtl/pong_game_sequencer_if.sv
// Bundle between the Pong match sequencer, the frame timer/physics engine and the score display.
// The master side drives frame timing, the user controls and the engine replies. The slave side is the sequencer.
interface pong_game_sequencer_if #(
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start_btn;
    logic               pause;
    logic               step_ack;
    logic               miss_l;
    logic               miss_r;
    logic               step_req;
    logic               ball_load;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [2:0]         state;
    logic               winner;
    logic               frame_overrun;

    modport master (
        output frame_tick, start_btn, pause, step_ack, miss_l, miss_r,
        input  step_req, ball_load, serve_dir, score_l, score_r, state, winner, frame_overrun
    );

    modport slave (
        input  frame_tick, start_btn, pause, step_ack, miss_l, miss_r,
        output step_req, ball_load, serve_dir, score_l, score_r, state, winner, frame_overrun
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong match controller: issues one physics step per frame over a req/ack handshake and runs serve/point/game-over flow.
// All outputs are registered. step_req is held until the engine acks, and late ticks only set the sticky overrun flag.
module pong_game_sequencer #(
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int CNT_W        = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    pong_game_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_STEP  = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               overrun_q, overrun_d;
    logic               step_req_q, step_req_d;
    logic               ball_load_q, ball_load_d;
    logic               start_prev_q;
    logic               start_edge;

    assign start_edge = bus.start_btn & ~start_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_dir_q  <= 1'b1;
            winner_q     <= 1'b0;
            overrun_q    <= 1'b0;
            step_req_q   <= 1'b0;
            ball_load_q  <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            overrun_q    <= overrun_d;
            step_req_q   <= step_req_d;
            ball_load_q  <= ball_load_d;
            start_prev_q <= bus.start_btn;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        overrun_d   = overrun_q;
        step_req_d  = step_req_q;
        ball_load_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    overrun_d   = 1'b0;
                    serve_dir_d = 1'b1;
                    ball_load_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_SERVE;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SERVE_LAST) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (bus.frame_tick && !bus.pause) begin
                    step_req_d = 1'b1;
                    state_d    = S_STEP;
                end
            end
            S_STEP: begin
                if (bus.frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (bus.step_ack) begin
                    step_req_d = 1'b0;
                    cnt_d      = '0;
                    // A double miss replays the serve with no score change
                    if (bus.miss_l && bus.miss_r) begin
                        state_d = S_POINT;
                    end else if (bus.miss_l) begin
                        score_r_d   = (score_r_q == WIN_S) ? score_r_q : score_r_q + 1'b1;
                        serve_dir_d = 1'b0;
                        state_d     = S_POINT;
                    end else if (bus.miss_r) begin
                        score_l_d   = (score_l_q == WIN_S) ? score_l_q : score_l_q + 1'b1;
                        serve_dir_d = 1'b1;
                        state_d     = S_POINT;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_POINT: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == POINT_LAST) begin
                        cnt_d = '0;
                        if (score_l_q == WIN_S || score_r_q == WIN_S) begin
                            winner_d = (score_r_q == WIN_S);
                            state_d  = S_OVER;
                        end else begin
                            ball_load_d = 1'b1;
                            state_d     = S_SERVE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.step_req      = step_req_q;
    assign bus.ball_load     = ball_load_q;
    assign bus.serve_dir     = serve_dir_q;
    assign bus.score_l       = score_l_q;
    assign bus.score_r       = score_r_q;
    assign bus.state         = state_q;
    assign bus.winner        = winner_q;
    assign bus.frame_overrun = overrun_q;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed match flow with randomized frame gaps, ack latencies and rally outcomes,
// checked against a point-level score/serve model.
module tb_pong_game_sequencer;
    localparam int WIN = 7;
    localparam int SW  = 4;
    localparam int SF  = 60;
    localparam int PF  = 30;
    localparam int CW  = 8;
    localparam int IDLE = 0, SERVE = 1, PLAY = 2, STEP = 3, POINT = 4, OVER = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pong_game_sequencer_if #(.SCORE_W(SW)) bus();

    pong_game_sequencer #(
        .WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .CNT_W(CW)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int m_sl, m_sr, m_sd, m_win, m_ovr;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st);
        check({tag, "_state"}, int'(bus.state), st);
        check({tag, "_score_l"}, int'(bus.score_l), m_sl);
        check({tag, "_score_r"}, int'(bus.score_r), m_sr);
        check({tag, "_serve_dir"}, int'(bus.serve_dir), m_sd);
        check({tag, "_overrun"}, int'(bus.frame_overrun), m_ovr);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        cyc($urandom_range(0, 2));
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
    endtask

    function automatic void model_point(input bit ml, input bit mr);
        if (ml && !mr) begin
            m_sr = (m_sr < WIN) ? m_sr + 1 : WIN;
            m_sd = 0;
        end else if (mr && !ml) begin
            m_sl = (m_sl < WIN) ? m_sl + 1 : WIN;
            m_sd = 1;
        end
    endfunction

    task automatic press_start();
        bus.start_btn = 1'b1;
        cyc(1);
        m_sl = 0; m_sr = 0; m_sd = 1; m_ovr = 0;
        check("start_load", int'(bus.ball_load), 1);
        check("start_req", int'(bus.step_req), 0);
        check_all("start", SERVE);
        cyc(1);
        check("start_load_once", int'(bus.ball_load), 0);
        check("start_held_state", int'(bus.state), SERVE);
        bus.start_btn = 1'b0;
        cyc(1);
    endtask

    task automatic serve_phase();
        for (int i = 0; i < SF - 1; i++) begin
            frame();
            check("serve_hold", int'(bus.state), SERVE);
        end
        frame();
        check_all("serve_done", PLAY);
        check("serve_done_load", int'(bus.ball_load), 0);
    endtask

    task automatic do_step(input int lat, input bit ml, input bit mr);
        int hi;
        frame();
        check("step_enter", int'(bus.state), STEP);
        check("step_req_on", int'(bus.step_req), 1);
        check("step_no_load", int'(bus.ball_load), 0);
        hi = 1;
        repeat (lat - 1) begin
            cyc(1);
            if (bus.step_req === 1'b1) hi++;
        end
        bus.step_ack = 1'b1;
        bus.miss_l   = ml;
        bus.miss_r   = mr;
        cyc(1);
        bus.step_ack = 1'b0;
        bus.miss_l   = 1'b0;
        bus.miss_r   = 1'b0;
        model_point(ml, mr);
        check("req_len", hi, lat);
        check("step_req_off", int'(bus.step_req), 0);
        check_all("step_res", (ml || mr) ? POINT : PLAY);
    endtask

    task automatic point_phase();
        for (int i = 0; i < PF - 1; i++) begin
            frame();
            check("point_hold", int'(bus.state), POINT);
        end
        frame();
        if (m_sl == WIN || m_sr == WIN) begin
            m_win = (m_sr == WIN) ? 1 : 0;
            check_all("pt_over", OVER);
            check("pt_winner", int'(bus.winner), m_win);
            check("pt_over_load", int'(bus.ball_load), 0);
        end else begin
            check_all("pt_serve", SERVE);
            check("pt_load", int'(bus.ball_load), 1);
            cyc(1);
            check("pt_load_once", int'(bus.ball_load), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int kind;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.pause      = 1'b0;
        bus.step_ack   = 1'b0;
        bus.miss_l     = 1'b0;
        bus.miss_r     = 1'b0;
        rst_n          = 1'b0;
        m_sl = 0; m_sr = 0; m_sd = 1; m_ovr = 0; m_win = 0;

        // Reset values
        cyc(3);
        check_all("reset", IDLE);
        check("reset_req", int'(bus.step_req), 0);
        check("reset_load", int'(bus.ball_load), 0);
        check("reset_winner", int'(bus.winner), 0);
        rst_n = 1'b1;
        cyc(2);
        check_all("idle", IDLE);

        // Start, serve countdown, start edge ignored during play
        press_start();
        serve_phase();
        bus.start_btn = 1'b1;
        cyc(2);
        check("play_start_ignored", int'(bus.state), PLAY);
        check("play_start_no_load", int'(bus.ball_load), 0);
        bus.start_btn = 1'b0;
        cyc(1);

        // Plain rallies
        do_step(5, 1'b0, 1'b0);
        do_step($urandom_range(1, 8), 1'b0, 1'b0);

        // Left miss then right miss
        do_step($urandom_range(1, 6), 1'b1, 1'b0);
        point_phase();
        serve_phase();
        do_step($urandom_range(1, 6), 1'b0, 1'b1);
        point_phase();
        serve_phase();

        // Overrun: ack withheld across two frames
        frame();
        check("ovr_step", int'(bus.state), STEP);
        frame();
        frame();
        m_ovr = 1;
        check_all("ovr_hold", STEP);
        check("ovr_req_held", int'(bus.step_req), 1);
        bus.step_ack = 1'b1;
        cyc(1);
        bus.step_ack = 1'b0;
        check_all("ovr_back", PLAY);
        cyc(3);
        check("ovr_no_queue", int'(bus.step_req), 0);

        // Pause drops frame ticks
        bus.pause = 1'b1;
        repeat (3) frame();
        check("pause_state", int'(bus.state), PLAY);
        check("pause_req", int'(bus.step_req), 0);
        bus.pause = 1'b0;

        // Double miss replays the serve
        do_step($urandom_range(1, 6), 1'b1, 1'b1);
        point_phase();
        serve_phase();

        // Right misses until left wins
        while (m_sl < WIN) begin
            do_step($urandom_range(1, 4), 1'b0, 1'b1);
            point_phase();
            if (m_sl < WIN) serve_phase();
        end
        bus.step_ack = 1'b1;
        bus.miss_l   = 1'b1;
        cyc(1);
        bus.step_ack = 1'b0;
        bus.miss_l   = 1'b0;
        repeat (3) frame();
        check_all("over_hold", OVER);
        check("over_winner", int'(bus.winner), 0);

        // Restart from OVER, then a randomized match
        press_start();
        serve_phase();
        guard = 0;
        while (!(m_sl == WIN || m_sr == WIN) && guard < 60) begin
            guard++;
            repeat ($urandom_range(0, 2)) do_step($urandom_range(1, 4), 1'b0, 1'b0);
            kind = $urandom_range(0, 2);
            do_step($urandom_range(1, 4), (kind == 0 || kind == 2), (kind == 1 || kind == 2));
            point_phase();
            if (!(m_sl == WIN || m_sr == WIN)) serve_phase();
        end
        check("rand_match_over", int'(bus.state), OVER);

        // Reset mid-handshake, late ack ignored
        press_start();
        serve_phase();
        frame();
        check("rst_step", int'(bus.state), STEP);
        rst_n = 1'b0;
        cyc(1);
        m_sl = 0; m_sr = 0; m_sd = 1; m_ovr = 0;
        check("rst_req_drop", int'(bus.step_req), 0);
        check_all("rst_mid", IDLE);
        rst_n = 1'b1;
        bus.step_ack = 1'b1;
        bus.miss_l   = 1'b1;
        cyc(1);
        bus.step_ack = 1'b0;
        bus.miss_l   = 1'b0;
        cyc(1);
        check_all("late_ack", IDLE);
        check("late_ack_winner", int'(bus.winner), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Top-level match controller for the Pong datapath. It sequences the ball/paddle physics engine once per video frame through a req/ack handshake and runs the match flow: idle, serve delay, play, point pause and game over. It tracks both players' scores, decides serve direction, and commands the engine to reload the ball at centre. It sits between the frame-timing generator and the physics engine; the engine holds no game-level state.

Parameters:
WIN_SCORE, 7, score that ends the match (1..2^SCORE_W-1)
SCORE_W, 4, width of each score counter
SERVE_FRAMES, 60, frame ticks spent in SERVE before play starts (>=1)
POINT_FRAMES, 30, frame ticks spent in POINT pause (>=1)
CNT_W, 8, width of the frame-delay counter (must hold max of SERVE_FRAMES, POINT_FRAMES)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
start_btn  in  1  level; a 0->1 edge (detected internally, registered) starts or restarts a match
pause  in  1  level; while high in PLAY, no engine steps are issued
step_ack  in  1  engine done with one physics step; miss_l/miss_r valid in same cycle
miss_l  in  1  ball passed left goal during the acked step (qualified by step_ack)
miss_r  in  1  ball passed right goal during the acked step (qualified by step_ack)
step_req  out  1  request one physics step; held until step_ack
ball_load  out  1  one-cycle pulse: engine reloads ball to centre with direction serve_dir
serve_dir  out  1  1 = serve right, 0 = serve left
score_l  out  SCORE_W  left player score
score_r  out  SCORE_W  right player score
state  out  3  IDLE=0 SERVE=1 PLAY=2 STEP=3 POINT=4 OVER=5
winner  out  1  valid in OVER: 0 = left won, 1 = right won
frame_overrun  out  1  sticky: frame_tick arrived while in STEP

Behaviour:
- Reset: state=IDLE; step_req=0, ball_load=0, serve_dir=1, scores=0, winner=0, frame_overrun=0, delay counter=0, edge-detect register=0. Reset mid-handshake drops step_req immediately. A step_ack arriving afterwards is ignored.
- IDLE: outputs static. On a start edge: scores=0, frame_overrun=0, serve_dir=1, ball_load pulses on the next cycle. Then go to SERVE with counter=0.
- SERVE: counter increments on each frame_tick. On the tick that makes counter==SERVE_FRAMES, go to PLAY the next cycle.
- PLAY: on frame_tick with pause=0, assert step_req the next cycle and go to STEP. A frame_tick with pause=1 is dropped.
- STEP: step_req stays high until the cycle step_ack=1 is sampled; it deasserts the next cycle.
  - ack with miss_l=0, miss_r=0: return to PLAY.
  - ack with miss_l=1 only: score_r+1; serve_dir=0 (serve toward the player who lost the point); go to POINT.
  - ack with miss_r=1 only: score_l+1; serve_dir=1; go to POINT.
  - ack with both set: no score change; serve_dir unchanged; go to POINT (replayed serve).
  - frame_tick while in STEP: frame_overrun=1 (sticky). The tick is not queued.
  - step_ack outside STEP: ignored.
- Score arithmetic: each counter saturates at WIN_SCORE and never wraps.
- POINT: counter is reset on entry and counts frame_ticks up to POINT_FRAMES. Then:
  - if either score==WIN_SCORE: go to OVER; winner = 1 if score_r==WIN_SCORE, else 0.
  - otherwise: pulse ball_load for one cycle and go to SERVE.
- OVER: scores and winner are held. A start edge behaves as in IDLE (clear scores, ball_load, SERVE).
- A start edge in SERVE, PLAY, STEP or POINT is ignored. A start_btn held high generates only one edge.
- ball_load is never high for more than one consecutive cycle. step_req and ball_load are never high together.
- frame_tick coinciding with a state transition is consumed only by the state that is current in that cycle.

Test Plan:
1. Reset, start_btn 0->1 -> ball_load pulses once with serve_dir=1. state goes SERVE, then PLAY after exactly 60 frame_ticks.
2. In PLAY, frame_tick, then engine acks 5 cycles later with no miss -> step_req high for exactly 5 cycles, state returns to PLAY, scores stay 0.
3. Ack with miss_l=1 -> score_r=1, serve_dir=0, POINT for 30 ticks, then one ball_load pulse and SERVE. Repeat with miss_r=1 -> score_l=1, serve_dir=1.
4. Seven miss_r points -> score_l=7, state=OVER, winner=0. Further stimulus leaves the scores at 7. A start edge clears both scores and enters SERVE.
5. Hold step_ack low across 2 frame_ticks -> frame_overrun=1 and only one step_req episode. Assert pause in PLAY -> no step_req on subsequent ticks.
6. Assert rst_n low while in STEP -> next cycle state=IDLE, step_req=0. A late step_ack causes no score change. Ack with miss_l and miss_r both set -> no score change, then POINT -> SERVE.
